// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and word type for the async FIFO and its read-side adapter.
package fifo_pkg;
   localparam int DATA_WIDTH  = 4;
   localparam int ADDR_WIDTH  = 2;
   localparam int STATS_WIDTH = 16;
   typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// fifo_rd_prefetch_buf: prefetch storage, registered write at tail, combinational read at head.
module fifo_rd_prefetch_buf
   import fifo_pkg::*;
#(
   parameter int data_width = DATA_WIDTH,
   parameter int addr_width = ADDR_WIDTH
) (
   input  logic                  rd_clk,
   input  logic                  wr_en,
   input  logic [addr_width-1:0] wr_addr,
   input  logic [data_width-1:0] wr_data,
   input  logic [addr_width-1:0] rd_addr,
   output logic [data_width-1:0] rd_data
);
   localparam int depth = 1 << addr_width;
   logic [data_width-1:0] mem_q [depth];
   logic [data_width-1:0] mem_d [depth];
   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
   end
   always_ff @(posedge rd_clk) mem_q <= mem_d;
   assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: turns the FIFO's 1-cycle-latency read port into a valid/ready stream.
// Optional FIFO_RD_STATS_EN adds word_cnt / stall_cnt outputs.
module fifo_rd_stream_adapter
   import fifo_pkg::*;
#(
   parameter int data_width     = DATA_WIDTH,
   parameter int buf_addr_width = ADDR_WIDTH
) (
   input  logic                      rd_clk,
   input  logic                      rd_reset,
   input  logic                      fifo_empty,
   input  logic [data_width-1:0]     fifo_data_out,
   output logic                      fifo_rd_en,
   output logic                      m_valid,
   output logic [data_width-1:0]     m_data,
   input  logic                      m_ready,
`ifdef FIFO_RD_STATS_EN
   output logic [STATS_WIDTH-1:0]    word_cnt,
   output logic [STATS_WIDTH-1:0]    stall_cnt,
`endif
   output logic [buf_addr_width:0]   buf_count
);
   localparam int depth = 1 << buf_addr_width;
   logic [buf_addr_width-1:0] head_q, head_d, tail_q, tail_d;
   logic [buf_addr_width:0]   count_q, count_d;
   logic                      inflight_q, inflight_d;
   logic                      pop;
   logic [buf_addr_width+1:0] occupancy;
   // One slot stays reserved so a word already requested always has somewhere to land.
   assign occupancy  = {1'b0, count_q} + (buf_addr_width+2)'(inflight_q);
   assign fifo_rd_en = !rd_reset && !fifo_empty && (occupancy < (buf_addr_width+2)'(depth-1));
   assign m_valid    = count_q != '0;
   assign buf_count  = count_q;
   always_comb begin
      pop        = m_valid && m_ready;
      inflight_d = fifo_rd_en && !fifo_empty;
      tail_d     = inflight_q ? tail_q + 1'b1 : tail_q;
      head_d     = pop ? head_q + 1'b1 : head_q;
      count_d    = (inflight_q && !pop) ? count_q + 1'b1 :
                   (!inflight_q && pop) ? count_q - 1'b1 : count_q;
   end
   always_ff @(posedge rd_clk or posedge rd_reset) begin
      if (rd_reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end
   fifo_rd_prefetch_buf #(
      .data_width (data_width),
      .addr_width (buf_addr_width)
   ) u_buf (
      .rd_clk  (rd_clk),
      .wr_en   (inflight_q),
      .wr_addr (tail_q),
      .wr_data (fifo_data_out),
      .rd_addr (head_q),
      .rd_data (m_data)
   );
`ifdef FIFO_RD_STATS_EN
   logic [STATS_WIDTH-1:0] word_cnt_q, word_cnt_d, stall_cnt_q, stall_cnt_d;
   always_comb begin
      word_cnt_d  = pop ? word_cnt_q + 1'b1 : word_cnt_q;
      stall_cnt_d = (m_valid && !m_ready && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end
   always_ff @(posedge rd_clk or posedge rd_reset) begin
      if (rd_reset) begin
         word_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         word_cnt_q  <= word_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
   assign word_cnt  = word_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: directed bench with a behavioural registered-output FIFO source.
`timescale 1ns/1ns
module tb_fifo_rd_stream_adapter;
   localparam int DW = 4;
   localparam int AW = 2;
   logic          rd_clk = 1'b0;
   logic          rd_reset = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data_out = '0;
   logic          m_ready = 1'b0;
   logic          fifo_rd_en, m_valid;
   logic [DW-1:0] m_data;
   logic [AW:0]   buf_count;
`ifdef FIFO_RD_STATS_EN
   logic [15:0]   word_cnt, stall_cnt;
`endif
   fifo_rd_stream_adapter #(.data_width(DW), .buf_addr_width(AW)) dut (
      .rd_clk        (rd_clk),
      .rd_reset      (rd_reset),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_rd_en    (fifo_rd_en),
      .m_valid       (m_valid),
      .m_data        (m_data),
      .m_ready       (m_ready),
`ifdef FIFO_RD_STATS_EN
      .word_cnt      (word_cnt),
      .stall_cnt     (stall_cnt),
`endif
      .buf_count     (buf_count)
   );
   always #10 rd_clk = ~rd_clk;
   int passed = 0;
   int total = 0;
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask
   // FIFO source: registered data_out and empty flag, words taken from src[rd_idx..src_n-1]
   logic [DW-1:0] src [64];
   int src_n = 0;
   int rd_idx = 0;
   always @(posedge rd_clk or posedge rd_reset) begin
      if (rd_reset) begin
         rd_idx     <= 0;
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= src[rd_idx];
            rd_idx        <= rd_idx + 1;
         end
         fifo_empty <= (rd_idx + ((fifo_rd_en && !fifo_empty) ? 1 : 0)) >= src_n;
      end
   end
   task automatic load_seq(input int first, input int n);
      for (int i = 0; i < n; i++) src[src_n+i] = DW'(first + i);
      src_n += n;
   endtask
   // Stream monitor, sampling 2 ns before each rising edge
   logic [DW-1:0] got [$];
   int hold_err = 0;
   int rd_err = 0;
   logic hold = 1'b0;
   logic [DW-1:0] hold_data = '0;
   always @(negedge rd_clk) begin
      #8;
      if (rd_reset) hold = 1'b0;
      else begin
         if (fifo_rd_en && fifo_empty) rd_err++;
         if (hold && !(m_valid && m_data == hold_data)) hold_err++;
         hold = m_valid && !m_ready;
         hold_data = m_data;
         if (m_valid && m_ready) got.push_back(m_data);
      end
   end
   task automatic chk_seq(input string name, input int base, input int first, input int n);
      chk({name, "_len"}, got.size() - base, n);
      for (int i = 0; i < n && base + i < got.size(); i++) chk({name, "_word"}, int'(got[base+i]), first + i);
   endtask
   typedef struct {
      logic ready;
      logic en;
      logic v;
      int   c;
      int   d;
   } vec_t;
   vec_t tbl [17];
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      int base, req_c, val_c, beats, bubbles, n;
      tbl = '{'{0,0,0,0,0}, '{0,1,0,0,0}, '{0,1,0,0,0}, '{0,1,1,1,1}, '{0,0,1,2,1}, '{0,0,1,3,1},
              '{0,0,1,3,1}, '{0,0,1,3,1}, '{1,0,1,3,1}, '{1,1,1,2,2}, '{1,1,1,1,3}, '{1,1,1,1,4},
              '{1,1,1,1,5}, '{1,1,1,1,6}, '{1,0,1,1,7}, '{1,0,1,1,8}, '{1,0,0,0,0}};
      repeat (2) @(negedge rd_clk);
      #8;
      chk("reset_valid", m_valid, 0);
      chk("reset_rd_en", fifo_rd_en, 0);
      chk("reset_count", buf_count, 0);
      @(negedge rd_clk) rd_reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge rd_clk);
         #8;
         chk("idle_rd_en", fifo_rd_en, 0);
      end
      // Continuous ready: latency and back-to-back beats
      @(negedge rd_clk);
      m_ready = 1'b1;
      load_seq(1, 8);
      base = got.size();
      req_c = -1; val_c = -1; beats = 0; bubbles = 0;
      for (int c = 0; c < 20; c++) begin
         if (c != 0) @(negedge rd_clk);
         #8;
         if (fifo_rd_en && req_c < 0) req_c = c;
         if (m_valid && val_c < 0) val_c = c;
         if (val_c >= 0 && beats < 8) begin
            if (m_valid) beats++;
            else bubbles++;
         end
      end
      chk("first_latency", val_c - req_c, 2);
      chk("bubbles", bubbles, 0);
      chk_seq("burst", base, 1, 8);
      // Backpressure then drain, cycle by cycle
      base = got.size();
      for (int i = 0; i < 17; i++) begin
         @(negedge rd_clk);
         if (i == 0) load_seq(1, 8);
         m_ready = tbl[i].ready;
         #8;
         chk($sformatf("bp_rd_en[%0d]", i), fifo_rd_en, tbl[i].en);
         chk($sformatf("bp_valid[%0d]", i), m_valid, tbl[i].v);
         chk($sformatf("bp_count[%0d]", i), buf_count, tbl[i].c);
         if (tbl[i].v) chk($sformatf("bp_data[%0d]", i), m_data, tbl[i].d);
      end
      @(negedge rd_clk);
      #8;
      chk_seq("backpressure", base, 1, 8);
      // Alternating ready
      base = got.size();
      for (int c = 0; c < 40; c++) begin
         @(negedge rd_clk);
         if (c == 0) load_seq(10, 5);
         m_ready = (c % 2 == 0);
      end
      @(negedge rd_clk);
      #8;
      chk_seq("toggle", base, 10, 5);
      chk("rd_en_while_empty", rd_err, 0);
      chk("hold_stable", hold_err, 0);
      // Reset with buffered and in-flight words
      @(negedge rd_clk);
      m_ready = 1'b0;
      load_seq(1, 8);
      n = 0;
      #8;
      while (buf_count != 2 && n < 20) begin
         @(negedge rd_clk);
         #8;
         n++;
      end
      chk("pre_reset_count", buf_count, 2);
      #1 rd_reset = 1'b1;
      #1;
      chk("async_reset_count", buf_count, 0);
      chk("async_reset_valid", m_valid, 0);
      chk("async_reset_rd_en", fifo_rd_en, 0);
      @(negedge rd_clk);
      src_n = 0;
      @(negedge rd_clk) rd_reset = 1'b0;
      base = got.size();
      @(negedge rd_clk);
      load_seq(9, 2);
      m_ready = 1'b1;
      repeat (15) @(negedge rd_clk);
      #8;
      chk_seq("after_reset", base, 9, 2);
`ifdef FIFO_RD_STATS_EN
      @(negedge rd_clk) rd_reset = 1'b1;
      @(negedge rd_clk);
      src_n = 0;
      rd_reset = 1'b0;
      m_ready = 1'b0;
      @(negedge rd_clk);
      load_seq(1, 5);
      n = 0;
      #8;
      while (!m_valid && n < 20) begin
         @(negedge rd_clk);
         #8;
         n++;
      end
      repeat (3) @(posedge rd_clk);
      @(negedge rd_clk) m_ready = 1'b1;
      repeat (15) @(negedge rd_clk);
      #8;
      chk("word_cnt", word_cnt, 5);
      chk("stall_cnt", stall_cnt, 3);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
